conv_tile_loader: RTL and testbench
===================================

# conv_tile_loader

Writer side of the 3x3 systolic convolution array. Accepts a byte stream over a valid/ready handshake, assembles one 3x3 filter and one 4x4 input tile into held parallel registers, then releases the array from reset for a fixed run window. It signals completion and holds the tile and the array state until the result consumer acknowledges. It sits between the host/DMA byte stream and the systolic array's parallel tile inputs.

## Interface
- RUN_CYCLES, 16: cycles the array runs after release before `done` is raised; legal range 12..255.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  8  stream byte.
- s_valid  in  1  `s_data` is valid this cycle.
- s_ready  out  1  loader accepts a byte this cycle; transfer occurs when `s_valid && s_ready`.
- result_ack  in  1  consumer has taken the array results; honoured only in DONE.
- fil_flat  out  72  filter tile; `fil_rc` is at `[8*(3*(r-1)+(c-1)) +: 8]`, with r and c in the range 1..3.
- in_flat  out  128  input tile; `in_rc` is at `[8*(4*(r-1)+(c-1)) +: 8]`, with r and c in the range 1..4.
- array_rst  out  1  drives the array's reset; high holds the array cleared.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse on entry to DONE.

## Operation
- States: IDLE, LOAD_FIL, LOAD_IN, RUN, DONE. The state is encoded in registers; outputs are decoded from the state register only.
- IDLE: entered on reset. Moves to LOAD_FIL unconditionally on the first clock edge after reset is released.
- LOAD_FIL:
  - `s_ready` = 1.
  - Each accepted byte is written to the filter slot indexed by `byte_cnt` (0..8), in row-major order fil11, fil12, …, fil33.
  - On the 9th accepted byte: `byte_cnt` returns to 0 and the state moves to LOAD_IN.
- LOAD_IN:
  - `s_ready` = 1.
  - Each accepted byte is written to the input slot indexed by `byte_cnt` (0..15), in row-major order in11, …, in44.
  - On the 16th accepted byte: the state moves to RUN and `run_cnt` is cleared.
- RUN:
  - `s_ready` = 0 and `array_rst` = 0.
  - `run_cnt` increments every cycle.
  - When `run_cnt == RUN_CYCLES-1`, the state moves to DONE on that edge.
- DONE:
  - `s_ready` = 0 and `array_rst` = 0; the array outputs stay stable because the array is fed zeros after its feed window.
  - `done` = 1 only in the first DONE cycle.
  - `result_ack` = 1 moves the state to LOAD_FIL and clears `byte_cnt`. This includes an ack in the first DONE cycle.
- `array_rst` = 1 in IDLE, LOAD_FIL and LOAD_IN.
- `fil_flat` and `in_flat` change only on an accepted byte. The previous tile stays visible until each slot is overwritten.
- `result_ack` is ignored outside DONE. Bytes presented with `s_valid` while `s_ready` = 0 are not consumed.
- Width rules:
  - `byte_cnt` is 4 bits and never exceeds 15.
  - `run_cnt` is 8 bits.
  - No arithmetic is applied to the data bytes; they pass through unmodified.

## Timing
- Reset values:
  - State = IDLE.
  - `s_ready` = 0, `array_rst` = 1, `busy` = 0, `done` = 0.
  - `fil_flat` = 0, `in_flat` = 0, `byte_cnt` = 0, `run_cnt` = 0.
- `s_ready` rises in the first cycle after the first edge following reset release.
- Let the 25th byte be accepted at edge N:
  - From edge N: `s_ready` = 0, `array_rst` = 0, `busy` = 1.
  - At edge N+RUN_CYCLES: the state enters DONE, and `done` is high for exactly one cycle.
- Let `result_ack` be sampled high in DONE at edge M:
  - From edge M: `array_rst` = 1, `busy` = 0, `s_ready` = 1.
  - A byte can be accepted at edge M+1.
- With `s_valid` held high continuously, the 25 bytes take 25 consecutive cycles with no bubbles.
- Reset mid-operation, in any state: outputs return to their reset values at once. A partial tile is discarded, the tile registers are zeroed, and the array is held in reset.

## Test plan
- Reset check: pulse `rst` during any state. Required: `array_rst` = 1, `s_ready` = 0, `busy` = 0, `done` = 0, both tile buses = 0. `s_ready` = 1 one edge after release.
- Back-to-back load: send bytes 1..9 then 10..25 with `s_valid` held high. Required:
  - `fil_flat[7:0]` = 1, `fil_flat[71:64]` = 9, `in_flat[7:0]` = 10, `in_flat[127:120]` = 25.
  - `s_ready` = 0 after the 25th byte.
  - `done` pulses exactly 16 cycles later.
- Bubbled stream: insert random `s_valid` gaps of 0..3 cycles into the same stream. Required: identical tile buses, no dropped or duplicated bytes, `done` 16 cycles after the last byte.
- Ack handling: hold `result_ack` = 1 throughout RUN. Required: no state change until DONE, then LOAD_FIL on the very next edge with `done` high for 1 cycle. Then load a second tile 101..125. Required: the buses reflect the new tile.
- Mid-load reset: assert `rst` after 12 accepted bytes. Required: buses = 0; a fresh 25-byte load then completes correctly.
- Backpressure: hold `s_valid` = 1 with byte 0xAA through RUN and DONE. Required: nothing is accepted and `in_flat` is unchanged. After ack, 0xAA is accepted as fil11.

Source files
------------

// File: rtl/conv_tile_loader.sv
// Byte-stream loader for the 3x3 systolic convolution array: assembles a filter
// and an input tile, runs the array for RUN_CYCLES cycles, then waits for ack.
module conv_tile_loader #(
  parameter int RUN_CYCLES = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic         result_ack,
  output logic [71:0]  fil_flat,
  output logic [127:0] in_flat,
  output logic         array_rst,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_FIL,
    LOAD_IN,
    RUN,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] byte_cnt;
  logic [7:0] run_cnt;
  logic       accept;

  assign accept = s_valid && s_ready;

  // Control outputs are registered alongside the state so they always match it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= 4'd0;
      run_cnt   <= 8'd0;
      s_ready   <= 1'b0;
      array_rst <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      fil_flat  <= '0;
      in_flat   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          state   <= LOAD_FIL;
          s_ready <= 1'b1;
        end
        LOAD_FIL: begin
          if (accept) begin
            for (int i = 0; i < 9; i++) begin
              if (byte_cnt == 4'(i)) fil_flat[8*i +: 8] <= s_data;
            end
            if (byte_cnt == 4'd8) begin
              byte_cnt <= 4'd0;
              state    <= LOAD_IN;
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end
        end
        LOAD_IN: begin
          if (accept) begin
            for (int i = 0; i < 16; i++) begin
              if (byte_cnt == 4'(i)) in_flat[8*i +: 8] <= s_data;
            end
            byte_cnt <= byte_cnt + 4'd1;
            if (byte_cnt == 4'd15) begin
              state     <= RUN;
              run_cnt   <= 8'd0;
              s_ready   <= 1'b0;
              array_rst <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          run_cnt <= run_cnt + 8'd1;
          if (run_cnt == 8'(RUN_CYCLES - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          // Tile and array state are held until the consumer acknowledges.
          if (result_ack) begin
            state     <= LOAD_FIL;
            byte_cnt  <= 4'd0;
            s_ready   <= 1'b1;
            array_rst <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          s_ready   <= 1'b0;
          array_rst <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_loader.sv
// Directed/randomized bench for conv_tile_loader with a byte-level tile model.
module tb_conv_tile_loader;
  localparam int RUN_CYCLES = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_data;
  logic         s_valid;
  logic         s_ready;
  logic         result_ack;
  logic [71:0]  fil_flat;
  logic [127:0] in_flat;
  logic         array_rst;
  logic         busy;
  logic         done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nacc     = 0;
  int first_cyc, last_cyc, k;
  logic [7:0]   exp_fil [9];
  logic [7:0]   exp_in  [16];
  logic [7:0]   seq     [25];
  logic [71:0]  save_fil;
  logic [127:0] save_in;

  conv_tile_loader #(.RUN_CYCLES(RUN_CYCLES)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .result_ack(result_ack), .fil_flat(fil_flat), .in_flat(in_flat),
    .array_rst(array_rst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mfil();
    logic [71:0] f;
    for (int i = 0; i < 9; i++) f[8*i +: 8] = exp_fil[i];
    return f;
  endfunction

  function automatic logic [127:0] min_t();
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = exp_in[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) exp_fil[i] = 8'h00;
    for (int i = 0; i < 16; i++) exp_in[i] = 8'h00;
    nacc = 0;
  endtask

  // Present one byte after a gap; returns at the negedge after it was taken.
  task automatic send_byte(input logic [7:0] b, input int gap);
    s_valid = 1'b0;
    repeat (gap) @(negedge clk);
    s_data  = b;
    s_valid = 1'b1;
    for (int t = 0; t < 400 && s_ready !== 1'b1; t++) @(negedge clk);
    chk("ready_wait", s_ready, 1);
    @(negedge clk);
    if (nacc == 0) first_cyc = cyc;
    if (nacc < 9) exp_fil[nacc] = b;
    else exp_in[nacc-9] = b;
    nacc++;
    if (nacc == 25) begin
      nacc     = 0;
      last_cyc = cyc;
    end
  endtask

  task automatic load_seq(input int maxgap);
    for (int i = 0; i < 25; i++) send_byte(seq[i], $urandom_range(0, maxgap));
    s_valid = 1'b0;
  endtask

  task automatic rand_seq();
    for (int i = 0; i < 25; i++) seq[i] = 8'($urandom);
  endtask

  task automatic wait_done(output int kk);
    kk = -1;
    for (int t = 1; t <= 300; t++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        kk = t;
        break;
      end
    end
  endtask

  task automatic check_tiles(input string tag);
    chk({tag, "_fil"}, fil_flat, mfil());
    chk({tag, "_in"}, in_flat, min_t());
  endtask

  task automatic ack_and_check(input string tag);
    result_ack = 1'b1;
    @(negedge clk);
    result_ack = 1'b0;
    chk({tag, "_ack_ready"}, s_ready, 1);
    chk({tag, "_ack_busy"}, busy, 0);
    chk({tag, "_ack_arst"}, array_rst, 1);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; result_ack = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", s_ready, 0);
    chk("rst_arst", array_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    check_tiles("rst");
    rst = 1'b0;
    chk("rel_ready", s_ready, 0);
    @(negedge clk);
    chk("rel_ready_up", s_ready, 1);
    chk("rel_arst", array_rst, 1);

    // Back-to-back load of 1..25
    for (int i = 0; i < 25; i++) seq[i] = 8'(i + 1);
    load_seq(0);
    chk("b2b_fil11", fil_flat[7:0], 1);
    chk("b2b_fil33", fil_flat[71:64], 9);
    chk("b2b_in11", in_flat[7:0], 10);
    chk("b2b_in44", in_flat[127:120], 25);
    check_tiles("b2b");
    chk("b2b_span", last_cyc - first_cyc, 24);
    chk("b2b_ready_low", s_ready, 0);
    chk("b2b_busy", busy, 1);
    chk("b2b_arst", array_rst, 0);
    wait_done(k);
    chk("b2b_done_lat", k, RUN_CYCLES);
    @(negedge clk);
    chk("b2b_done_pulse", done, 0);
    chk("b2b_busy_done", busy, 1);
    chk("b2b_ready_done", s_ready, 0);
    ack_and_check("b2b");

    // Same stream with random bubbles
    load_seq(3);
    check_tiles("bub");
    wait_done(k);
    chk("bub_done_lat", k, RUN_CYCLES);
    ack_and_check("bub");

    // Ack held high throughout RUN, then a second tile 101..125
    rand_seq();
    load_seq(1);
    result_ack = 1'b1;
    wait_done(k);
    chk("ackh_done_lat", k, RUN_CYCLES);
    chk("ackh_busy", busy, 1);
    check_tiles("ackh");
    @(negedge clk);
    result_ack = 1'b0;
    chk("ackh_done_pulse", done, 0);
    chk("ackh_ready", s_ready, 1);
    chk("ackh_arst", array_rst, 1);
    for (int i = 0; i < 25; i++) seq[i] = 8'(101 + i);
    load_seq(0);
    check_tiles("t2");
    chk("t2_fil11", fil_flat[7:0], 101);
    chk("t2_in44", in_flat[127:120], 125);
    wait_done(k);
    chk("t2_done_lat", k, RUN_CYCLES);
    ack_and_check("t2");

    // Reset after 12 accepted bytes
    rand_seq();
    for (int i = 0; i < 12; i++) send_byte(seq[i], $urandom_range(0, 2));
    s_valid = 1'b0;
    chk("mid_partial_in1", in_flat[23:0], {exp_in[2], exp_in[1], exp_in[0]});
    rst = 1'b1;
    #1;
    model_reset();
    check_tiles("mid_rst");
    chk("mid_rst_arst", array_rst, 1);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rel_ready", s_ready, 1);
    rand_seq();
    load_seq(2);
    check_tiles("mid_reload");
    wait_done(k);
    chk("mid_done_lat", k, RUN_CYCLES);
    ack_and_check("mid");

    // Backpressure: 0xAA held valid through RUN and DONE
    rand_seq();
    load_seq(0);
    s_data  = 8'hAA;
    s_valid = 1'b1;
    save_fil = fil_flat;
    save_in  = in_flat;
    wait_done(k);
    chk("bp_done_lat", k, RUN_CYCLES);
    repeat (3) @(negedge clk);
    chk("bp_in_hold", in_flat, save_in);
    chk("bp_fil_hold", fil_flat, save_fil);
    check_tiles("bp_model");
    ack_and_check("bp");
    send_byte(8'hAA, 0);
    s_valid = 1'b0;
    chk("bp_fil11", fil_flat[7:0], 8'hAA);
    check_tiles("bp_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule
